// File: rtl/data_mem_responder_if.sv
// Load/store request/response channel between a core (master) and a data memory (slave).
interface data_mem_responder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [DATA_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [2:0]            req_funct3;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_funct3, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_funct3, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data memory answering one load/store at a time after a fixed latency,
// with little-endian byte/halfword lanes, load extension and an error response.
module data_mem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input logic                  clk,
    input logic                  rst,
    data_mem_responder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [DATA_WIDTH-1:0] ADDR_LIMIT = DATA_WIDTH'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state, state_next;
    logic [3:0]            cnt, cnt_next;
    logic                  exec;

    logic                  lat_write;
    logic [DATA_WIDTH-1:0] lat_addr, lat_wdata;
    logic [2:0]            lat_funct3;

    logic                  op_write;
    logic [DATA_WIDTH-1:0] op_addr, op_wdata;
    logic [2:0]            op_funct3;

    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
    logic [AW-1:0]         idx;
    logic [DATA_WIDTH-1:0] rd_word, ld_data, wlanes;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [3:0]            be;
    logic                  f3_legal, misaligned, out_of_range, op_err, mem_we;

    // A single-cycle latency executes on the acceptance edge, straight from the bus.
    always_comb begin
        if (state == IDLE) begin
            op_write  = bus.req_write;
            op_addr   = bus.req_addr;
            op_wdata  = bus.req_wdata;
            op_funct3 = bus.req_funct3;
        end else begin
            op_write  = lat_write;
            op_addr   = lat_addr;
            op_wdata  = lat_wdata;
            op_funct3 = lat_funct3;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        exec       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (LATENCY == 1) begin
                        exec       = 1'b1;
                        state_next = RESP;
                    end else begin
                        cnt_next   = 4'(LATENCY - 2);
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    exec       = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        f3_legal     = op_write ? (op_funct3 inside {3'b000, 3'b001, 3'b010})
                                : (op_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misaligned   = ((op_funct3[1:0] == 2'b01) && op_addr[0]) ||
                       ((op_funct3[1:0] == 2'b10) && (op_addr[1:0] != 2'b00));
        out_of_range = (op_addr >= ADDR_LIMIT);
        op_err       = !f3_legal || misaligned || out_of_range;
    end

    assign idx     = op_addr[2 +: AW];
    assign rd_word = mem[idx];
    assign rd_byte = rd_word[{op_addr[1:0], 3'b000} +: 8];
    assign rd_half = op_addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        case (op_funct3)
            3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
            3'b010:  ld_data = rd_word;
            3'b100:  ld_data = {24'b0, rd_byte};
            3'b101:  ld_data = {16'b0, rd_half};
            default: ld_data = '0;
        endcase
    end

    // Store data is replicated across lanes; the byte enables pick which lanes land.
    always_comb begin
        case (op_funct3[1:0])
            2'b00: begin
                be     = 4'b0001 << op_addr[1:0];
                wlanes = {4{op_wdata[7:0]}};
            end
            2'b01: begin
                be     = op_addr[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{op_wdata[15:0]}};
            end
            2'b10: begin
                be     = 4'b1111;
                wlanes = op_wdata;
            end
            default: begin
                be     = 4'b0000;
                wlanes = op_wdata;
            end
        endcase
    end

    assign mem_we = rst && exec && op_write && !op_err;

    // NOTE: the array has no reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_funct3 <= 3'b000;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (state == IDLE && bus.req_valid) begin
                lat_write  <= bus.req_write;
                lat_addr   <= bus.req_addr;
                lat_wdata  <= bus.req_wdata;
                lat_funct3 <= bus.req_funct3;
            end
            if (exec) begin
                rdata_q <= (op_err || op_write) ? '0 : ld_data;
                err_q   <= op_err;
            end
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Drives three responders (LATENCY 1, 2, 3) through one shared stimulus path and checks
// every cycle against a byte-addressed reference memory and transaction model.
module tb_data_mem_responder;
    localparam int DEPTH = 1024;
    localparam int LIMIT = 4 * DEPTH;
    localparam int TMO   = 50;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int          sel = 0;
    logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [2:0]  req_funct3 = 3'b000;

    data_mem_responder_if #(.DATA_WIDTH(32)) bus0();
    data_mem_responder_if #(.DATA_WIDTH(32)) bus1();
    data_mem_responder_if #(.DATA_WIDTH(32)) bus2();

    assign bus0.req_valid = req_valid && (sel == 0);
    assign bus1.req_valid = req_valid && (sel == 1);
    assign bus2.req_valid = req_valid && (sel == 2);
    assign bus0.rsp_ready = rsp_ready && (sel == 0);
    assign bus1.rsp_ready = rsp_ready && (sel == 1);
    assign bus2.rsp_ready = rsp_ready && (sel == 2);
    assign bus0.req_write = req_write;  assign bus1.req_write = req_write;  assign bus2.req_write = req_write;
    assign bus0.req_addr  = req_addr;   assign bus1.req_addr  = req_addr;   assign bus2.req_addr  = req_addr;
    assign bus0.req_wdata = req_wdata;  assign bus1.req_wdata = req_wdata;  assign bus2.req_wdata = req_wdata;
    assign bus0.req_funct3 = req_funct3; assign bus1.req_funct3 = req_funct3; assign bus2.req_funct3 = req_funct3;

    data_mem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(DEPTH), .LATENCY(1)) u_lat1 (.clk(clk), .rst(rst), .bus(bus0));
    data_mem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(DEPTH), .LATENCY(2)) u_lat2 (.clk(clk), .rst(rst), .bus(bus1));
    data_mem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(DEPTH), .LATENCY(3)) u_lat3 (.clk(clk), .rst(rst), .bus(bus2));

    logic        m_req_ready, m_rsp_valid, m_rsp_err;
    logic [31:0] m_rsp_rdata;
    always_comb begin
        case (sel)
            0: begin m_req_ready = bus0.req_ready; m_rsp_valid = bus0.rsp_valid; m_rsp_rdata = bus0.rsp_rdata; m_rsp_err = bus0.rsp_err; end
            1: begin m_req_ready = bus1.req_ready; m_rsp_valid = bus1.rsp_valid; m_rsp_rdata = bus1.rsp_rdata; m_rsp_err = bus1.rsp_err; end
            default: begin m_req_ready = bus2.req_ready; m_rsp_valid = bus2.rsp_valid; m_rsp_rdata = bus2.rsp_rdata; m_rsp_err = bus2.rsp_err; end
        endcase
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s (sel=%0d t=%0t): got %h, expected %h", name, sel, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  mdl [int unsigned];
    bit          pending = 0, done = 0;
    int          edge_cnt = 0, acc_edge = 0;
    logic        m_write;
    logic [31:0] m_addr, m_wdata, exp_rdata;
    logic [2:0]  m_f3;
    bit          exp_err;

    function automatic int lat_of(int s);
        return s + 1;
    endfunction

    function automatic int unsigned key(logic [31:0] a);
        return (int'(sel) << 16) | int'(a[15:0]);
    endfunction

    function automatic void model_exec();
        int          n;
        bit          legal;
        logic [31:0] v;
        legal     = m_write ? (m_f3 inside {3'd0, 3'd1, 3'd2}) : (m_f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        n         = 1 << m_f3[1:0];
        exp_err   = !legal || (m_addr % n != 0) || (m_addr >= LIMIT);
        exp_rdata = 32'h0;
        if (!exp_err) begin
            if (m_write) begin
                for (int i = 0; i < n; i++) mdl[key(m_addr + i)] = m_wdata[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < n; i++) v = v | (32'(mdl[key(m_addr + i)]) << (8*i));
                if (!m_f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
                exp_rdata = v;
            end
        end
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending = 0;
            done    = 0;
        end else begin
            edge_cnt++;
            if (!pending) begin
                if (req_valid) begin
                    pending  = 1;
                    acc_edge = edge_cnt;
                    m_write  = req_write;
                    m_addr   = req_addr;
                    m_wdata  = req_wdata;
                    m_f3     = req_funct3;
                end
            end else if (done) begin
                if (rsp_ready) begin
                    pending = 0;
                    done    = 0;
                end
            end
            if (pending && !done && (edge_cnt - acc_edge == lat_of(sel) - 1)) begin
                model_exec();
                done = 1;
            end
        end
    end

    // Per-cycle comparison of the selected responder against the model.
    always @(negedge clk) begin
        if (rst) begin
            check("req_ready", 32'(m_req_ready), 32'(!pending));
            check("rsp_valid", 32'(m_rsp_valid), 32'(done));
            if (done && m_rsp_valid) begin
                check("rsp_rdata", m_rsp_rdata, exp_rdata);
                check("rsp_err", 32'(m_rsp_err), 32'(exp_err));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic next_cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3,
                        input int hold, output logic [31:0] rd, output logic er, output int lat);
        int t;
        req_write = w; req_addr = a; req_wdata = wd; req_funct3 = f3; req_valid = 1'b1;
        rd = '0; er = 1'b0; lat = 0;
        t = 0;
        while (!m_req_ready && t < TMO) begin next_cyc(); t++; end
        if (t == TMO) begin
            check("accept_timeout", 32'(m_req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        next_cyc();
        req_valid = 1'b0;
        t = 0;
        while (!m_rsp_valid && t < TMO) begin next_cyc(); t++; end
        if (t == TMO) begin
            check("response_timeout", 32'(m_rsp_valid), 32'd1);
            return;
        end
        lat = t + 1;
        rd  = m_rsp_rdata;
        er  = m_rsp_err;
        repeat (hold) next_cyc();
        rsp_ready = 1'b1;
        next_cyc();
        rsp_ready = 1'b0;
    endtask

    task automatic expect_x(input string name, input logic w, input logic [31:0] a, input logic [31:0] wd,
                            input logic [2:0] f3, input logic [31:0] exp_rd, input logic exp_er);
        logic [31:0] rd;
        logic        er;
        int          lat;
        xact(w, a, wd, f3, 0, rd, er, lat);
        check({name, "_rdata"}, rd, exp_rd);
        check({name, "_err"}, 32'(er), 32'(exp_er));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (checks %0d)", n_checks);
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, first;
        logic        er;
        int          lat;

        repeat (2) next_cyc();
        check("reset_req_ready", 32'(m_req_ready), 32'd1);
        check("reset_rsp_valid", 32'(m_rsp_valid), 32'd0);
        check("reset_rsp_rdata", m_rsp_rdata, 32'd0);
        check("reset_rsp_err", 32'(m_rsp_err), 32'd0);
        rst = 1'b1;
        next_cyc();

        // LATENCY=2: store/load, sub-word access, partial stores, errors.
        sel = 1;
        xact(1'b1, 32'h20, 32'h8899AABB, 3'b010, 0, rd, er, lat);
        check("sw_latency", 32'(lat), 32'd2);
        check("sw_rdata", rd, 32'h0);
        check("sw_err", 32'(er), 32'd0);
        expect_x("lw_20",  1'b0, 32'h20, 32'h0, 3'b010, 32'h8899AABB, 1'b0);
        expect_x("lb_21",  1'b0, 32'h21, 32'h0, 3'b000, 32'hFFFFFFAA, 1'b0);
        expect_x("lbu_23", 1'b0, 32'h23, 32'h0, 3'b100, 32'h00000088, 1'b0);
        expect_x("lh_22",  1'b0, 32'h22, 32'h0, 3'b001, 32'hFFFF8899, 1'b0);
        expect_x("lhu_20", 1'b0, 32'h20, 32'h0, 3'b101, 32'h0000AABB, 1'b0);
        expect_x("sb_22",  1'b1, 32'h22, 32'h12345677, 3'b000, 32'h0, 1'b0);
        expect_x("sh_20",  1'b1, 32'h20, 32'hCAFE0001, 3'b001, 32'h0, 1'b0);
        expect_x("lw_part", 1'b0, 32'h20, 32'h0, 3'b010, 32'h88770001, 1'b0);
        expect_x("lw_mis", 1'b0, 32'h22, 32'h0, 3'b010, 32'h0, 1'b1);
        expect_x("sh_mis", 1'b1, 32'h21, 32'hFFFFFFFF, 3'b001, 32'h0, 1'b1);
        expect_x("lw_keep", 1'b0, 32'h20, 32'h0, 3'b010, 32'h88770001, 1'b0);
        expect_x("ld_f3_3", 1'b0, 32'h20, 32'h0, 3'b011, 32'h0, 1'b1);
        expect_x("sb_f3_4", 1'b1, 32'h20, 32'h0, 3'b100, 32'h0, 1'b1);
        expect_x("lw_oor", 1'b0, LIMIT, 32'h0, 3'b010, 32'h0, 1'b1);
        expect_x("sw_last", 1'b1, LIMIT - 4, 32'h5A5AC3C3, 3'b010, 32'h0, 1'b0);
        expect_x("lw_last", 1'b0, LIMIT - 4, 32'h0, 3'b010, 32'h5A5AC3C3, 1'b0);

        // LATENCY=3: reset while a store is in flight drops it.
        sel = 2;
        expect_x("pre_sw", 1'b1, 32'h10, 32'h11111111, 3'b010, 32'h0, 1'b0);
        req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'hDEADBEEF; req_funct3 = 3'b010; req_valid = 1'b1;
        next_cyc();
        req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_mid_rsp_valid", 32'(m_rsp_valid), 32'd0);
        check("rst_mid_req_ready", 32'(m_req_ready), 32'd1);
        next_cyc();
        rst = 1'b1;
        next_cyc();
        expect_x("lw_after_rst", 1'b0, 32'h10, 32'h0, 3'b010, 32'h11111111, 1'b0);

        // LATENCY=1: backpressure holds the response and blocks new requests.
        sel = 0;
        expect_x("pre_40", 1'b1, 32'h40, 32'h0BADF00D, 3'b010, 32'h0, 1'b0);
        expect_x("pre_44", 1'b1, 32'h44, 32'h12345678, 3'b010, 32'h0, 1'b0);
        req_write = 1'b0; req_addr = 32'h40; req_funct3 = 3'b010; req_valid = 1'b1;
        next_cyc();
        first = m_rsp_rdata;
        check("bp_first", first, 32'h0BADF00D);
        req_addr = 32'h44;
        for (int i = 0; i < 4; i++) begin
            next_cyc();
            check("bp_valid", 32'(m_rsp_valid), 32'd1);
            check("bp_ready", 32'(m_req_ready), 32'd0);
            check("bp_rdata", m_rsp_rdata, 32'h0BADF00D);
            check("bp_err", 32'(m_rsp_err), 32'd0);
        end
        rsp_ready = 1'b1;
        next_cyc();
        rsp_ready = 1'b0;
        check("bp_retire_ready", 32'(m_req_ready), 32'd1);
        check("bp_retire_valid", 32'(m_rsp_valid), 32'd0);
        next_cyc();
        req_valid = 1'b0;
        check("bp_second_valid", 32'(m_rsp_valid), 32'd1);
        check("bp_second_rdata", m_rsp_rdata, 32'h12345678);
        rsp_ready = 1'b1;
        next_cyc();
        rsp_ready = 1'b0;

        // Randomized traffic on each latency, checked by the per-cycle model compare.
        for (int s = 0; s < 3; s++) begin
            sel = s;
            next_cyc();
            for (int w = 0; w < 64; w++) xact(1'b1, 32'(w * 4), $urandom, 3'b010, 0, rd, er, lat);
            for (int n = 0; n < 150; n++) begin
                logic [31:0] a;
                int          r;
                r = $urandom_range(0, 15);
                if (r == 0)      a = 32'(LIMIT + $urandom_range(0, 63));
                else if (r == 1) a = 32'hFFFFFF00 | 32'($urandom_range(0, 255));
                else             a = 32'($urandom_range(0, 255));
                xact(1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)),
                     $urandom_range(0, 3), rd, er, lat);
                repeat ($urandom_range(0, 2)) next_cyc();
            end
        end

        next_cyc();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Word-organised data memory that acts as the responder on the core's load/store request/response interface. It accepts one request at a time through a valid/ready handshake and waits a programmable number of cycles. It then performs a byte, halfword or word access selected by funct3, with little-endian lanes and load sign/zero extension. It returns the result, or an error flag, on a response channel held until the core accepts it.

Parameters:
DATA_WIDTH, 32, data and address width (fixed at 32; other values unsupported)
DEPTH_WORDS, 1024, number of 32-bit words; valid byte addresses 0 to 4*DEPTH_WORDS-1
LATENCY, 2, cycles from request acceptance to rsp_valid; legal range 1 to 15

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low (block in reset while rst==0)
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_write  input  1  1=store, 0=load
req_addr  input  32  byte address
req_wdata  input  32  store data; the low byte or halfword is used for SB/SH
req_funct3  input  3  access size/sign, RISC-V load/store encoding
rsp_valid  output  1  response present
rsp_ready  input  1  core accepts response
rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors
rsp_err  output  1  misaligned, out-of-range or illegal-funct3 access

Behaviour:
- Reset (rst==0, asynchronous): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0. Memory contents are not reset. A request in flight is dropped and its store is never committed.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. Acceptance happens at a rising edge with req_valid&&req_ready. On acceptance the block latches write, addr, wdata and funct3.
  - LATENCY==1: go straight to RESP and execute the access at that same edge.
  - LATENCY>1: load counter with LATENCY-2 and go to WAIT.
- WAIT: req_ready=0. If counter==0, execute the access and go to RESP; otherwise decrement the counter.
- rsp_valid therefore asserts exactly LATENCY cycles after the acceptance edge.
- Execute step: compute err, write memory (store, no error), capture rsp_rdata and rsp_err.
- RESP: rsp_valid=1, req_ready=0. rsp_rdata and rsp_err hold stable until an edge with rsp_ready==1; that edge moves the FSM to IDLE with rsp_valid=0.
- No new request is accepted in the cycle a response retires. Minimum spacing between acceptances is LATENCY+1 cycles.
- req_* inputs are ignored outside IDLE.
- Error conditions, any one of which sets err=1:
  - funct3 illegal: loads allow 000, 001, 010, 100, 101; stores allow 000, 001, 010.
  - Halfword access with addr[0]!=0.
  - Word access with addr[1:0]!=0.
  - addr >= 4*DEPTH_WORDS.
- On error: no memory write, rsp_rdata=0, rsp_err=1.
- Word index = addr[31:2]. Byte lane = addr[1:0]. Halfword lane = addr[1]. Byte lane 0 = bits 7:0.
- Loads:
  - LB: sign-extend the selected byte. LBU: zero-extend it.
  - LH: sign-extend the selected halfword. LHU: zero-extend it.
  - LW: whole word.
- Stores:
  - SB writes req_wdata[7:0] into the addressed lane only.
  - SH writes req_wdata[15:0] into the addressed halfword only.
  - SW writes the full word.
  - Other lanes are preserved.
  - Store response: rsp_rdata=0, rsp_err=0.
- Read data is the memory content before any write in the same execute step. A load issued after a completed store sees the stored value.
- Memory is a plain register array, initially undefined. The bench must preload it, or store before it loads.

Test Plan:
- Reset mid-operation: LATENCY=3, SW addr 0x10 data 0xDEADBEEF accepted, rst driven low one cycle later -> rsp_valid=0, req_ready=1 immediately; a later LW 0x10 returns the prior value (preload 0x11111111), not 0xDEADBEEF.
- Store then load, LATENCY=2: SW 0x20 data 0x8899AABB accepted at edge N -> rsp_valid high at N+2 with rsp_err=0, rsp_rdata=0. Then LW 0x20 -> rsp_rdata=0x8899AABB.
- Sub-word loads on word 0x8899AABB at 0x20:
  - LB 0x21 -> 0xFFFFFFAA; LBU 0x23 -> 0x00000088.
  - LH 0x22 -> 0xFFFF8899; LHU 0x20 -> 0x0000AABB.
- Partial stores: SB 0x22 data 0x12345677, then SH 0x20 data 0xCAFE0001 -> LW 0x20 returns 0x88770001.
- Errors:
  - LW 0x22 -> rsp_err=1, rsp_rdata=0.
  - SH 0x21 -> rsp_err=1, memory unchanged.
  - funct3=011 load -> rsp_err=1.
  - LW 4*DEPTH_WORDS -> rsp_err=1.
- Backpressure, LATENCY=1: LW with rsp_ready=0 for 4 cycles -> rsp_valid, rsp_rdata and rsp_err stable; req_ready=0 with req_valid held high and no second acceptance. rsp_ready=1 -> IDLE on the next edge, and the next request is accepted one edge later.
